// File: rtl/psola_window_scheduler.sv
// Sequencing controller for the PSOLA path: ping-pong sample windows, pitch
// detection hand-off, period forwarding and paced playback reads.
module psola_window_scheduler #(
  parameter int WINDOW_SIZE        = 2048,
  parameter int SAMP_PLAY_DURATION = 2304
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sample_valid_in,
  output logic [$clog2(WINDOW_SIZE)-1:0] sample_addr_out,
  output logic                           sample_bank_out,
  output logic                           sample_valid_out,
  output logic                           yin_start_out,
  output logic                           yin_bank_out,
  input  logic [10:0]                    taumin_in,
  input  logic                           taumin_valid_in,
  output logic [10:0]                    tau_out,
  output logic                           tau_valid_out,
  input  logic                           psola_done_in,
  input  logic                           ring_empty_in,
  output logic                           read_trigger_out,
  output logic                           overrun_out,
  output logic                           underrun_out,
  output logic [1:0]                     state_out
);

  localparam int AW = $clog2(WINDOW_SIZE);
  localparam int CW = (SAMP_PLAY_DURATION > 1) ? $clog2(SAMP_PLAY_DURATION) : 1;
  localparam logic [CW-1:0] CAD_LAST = CW'(SAMP_PLAY_DURATION - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_TAU   = 2'd1,
    WAIT_PSOLA = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [AW-1:0] wr_count;
  logic          wr_bank;
  logic          playing;
  logic [CW-1:0] cadence;

  logic boundary;
  logic yin_start_d, tau_valid_d, overrun_set, playing_set;

  // The window closes on the sample that lands at the last address.
  assign boundary  = sample_valid_in && (&wr_count);
  assign state_out = state;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a signal unassigned and a latch can never be inferred.
  always_comb begin
    next_state  = state;
    yin_start_d = 1'b0;
    tau_valid_d = 1'b0;
    overrun_set = 1'b0;
    playing_set = 1'b0;
    case (state)
      IDLE: begin
        if (boundary) begin
          yin_start_d = 1'b1;
          next_state  = WAIT_TAU;
        end
      end
      WAIT_TAU: begin
        overrun_set = boundary;
        if (taumin_valid_in) begin
          tau_valid_d = 1'b1;
          next_state  = WAIT_PSOLA;
        end
      end
      WAIT_PSOLA: begin
        if (psola_done_in) begin
          playing_set = 1'b1;
          // A window finishing as PSOLA completes is handed straight on.
          if (boundary) begin
            yin_start_d = 1'b1;
            next_state  = WAIT_TAU;
          end else begin
            next_state  = IDLE;
          end
        end else begin
          overrun_set = boundary;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      wr_count         <= '0;
      wr_bank          <= 1'b0;
      playing          <= 1'b0;
      cadence          <= '0;
      sample_addr_out  <= '0;
      sample_bank_out  <= 1'b0;
      sample_valid_out <= 1'b0;
      yin_start_out    <= 1'b0;
      yin_bank_out     <= 1'b0;
      tau_out          <= '0;
      tau_valid_out    <= 1'b0;
      read_trigger_out <= 1'b0;
      overrun_out      <= 1'b0;
      underrun_out     <= 1'b0;
    end else begin
      state            <= next_state;
      sample_valid_out <= sample_valid_in;
      yin_start_out    <= yin_start_d;
      tau_valid_out    <= tau_valid_d;
      read_trigger_out <= 1'b0;

      if (sample_valid_in) begin
        sample_addr_out <= wr_count;
        sample_bank_out <= wr_bank;
        wr_count        <= wr_count + 1'b1;
        if (boundary) wr_bank <= ~wr_bank;
      end

      if (yin_start_d) yin_bank_out <= wr_bank;
      if (tau_valid_d) tau_out      <= taumin_in;
      if (overrun_set) overrun_out  <= 1'b1;
      if (playing_set) playing      <= 1'b1;

      if (playing) begin
        if (cadence == CAD_LAST) begin
          cadence <= '0;
          if (ring_empty_in) underrun_out     <= 1'b1;
          else               read_trigger_out <= 1'b1;
        end else begin
          cadence <= cadence + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_psola_window_scheduler.sv
// Directed bench for psola_window_scheduler with WINDOW_SIZE=8 and
// SAMP_PLAY_DURATION=10; expected values are hand-derived constants.
module tb_psola_window_scheduler;

  localparam int WS = 8;
  localparam int PD = 10;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        sample_valid_in = 1'b0;
  logic [2:0]  sample_addr_out;
  logic        sample_bank_out;
  logic        sample_valid_out;
  logic        yin_start_out;
  logic        yin_bank_out;
  logic [10:0] taumin_in = '0;
  logic        taumin_valid_in = 1'b0;
  logic [10:0] tau_out;
  logic        tau_valid_out;
  logic        psola_done_in = 1'b0;
  logic        ring_empty_in = 1'b0;
  logic        read_trigger_out;
  logic        overrun_out;
  logic        underrun_out;
  logic [1:0]  state_out;

  int errors = 0;
  int checks = 0;

  psola_window_scheduler #(.WINDOW_SIZE(WS), .SAMP_PLAY_DURATION(PD)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .sample_valid_in(sample_valid_in),
    .sample_addr_out(sample_addr_out), .sample_bank_out(sample_bank_out),
    .sample_valid_out(sample_valid_out),
    .yin_start_out(yin_start_out), .yin_bank_out(yin_bank_out),
    .taumin_in(taumin_in), .taumin_valid_in(taumin_valid_in),
    .tau_out(tau_out), .tau_valid_out(tau_valid_out),
    .psola_done_in(psola_done_in), .ring_empty_in(ring_empty_in),
    .read_trigger_out(read_trigger_out),
    .overrun_out(overrun_out), .underrun_out(underrun_out),
    .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " addr"},     32'(sample_addr_out), 0);
    check({tag, " bank"},     32'(sample_bank_out), 0);
    check({tag, " svalid"},   32'(sample_valid_out), 0);
    check({tag, " yin"},      32'(yin_start_out), 0);
    check({tag, " yin_bank"}, 32'(yin_bank_out), 0);
    check({tag, " tau"},      32'(tau_out), 0);
    check({tag, " tau_v"},    32'(tau_valid_out), 0);
    check({tag, " rd"},       32'(read_trigger_out), 0);
    check({tag, " ovr"},      32'(overrun_out), 0);
    check({tag, " unr"},      32'(underrun_out), 0);
    check({tag, " state"},    32'(state_out), 0);
  endtask

  // Push samples filling addresses [first, first+n) of bank exp_bank.
  task automatic push_samples(input string tag, input int first, input int n, input logic exp_bank);
    for (int i = 0; i < n; i++) begin
      sample_valid_in = 1'b1;
      tick();
      check({tag, " addr"}, 32'(sample_addr_out), 32'(first + i));
      check({tag, " bank"}, 32'(sample_bank_out), 32'(exp_bank));
    end
    sample_valid_in = 1'b0;
  endtask

  task automatic send_tau(input logic [10:0] tau);
    taumin_in       = tau;
    taumin_valid_in = 1'b1;
    tick();
    taumin_valid_in = 1'b0;
  endtask

  initial begin
    int yin_pulses;
    int rd_pulses;

    // Reset state
    repeat (2) tick();
    check_reset_values("reset");
    rst_in = 1'b1;
    tick();

    // First window: addresses 0..7 in bank 0, one yin_start on address 7
    yin_pulses = 0;
    for (int i = 0; i < WS; i++) begin
      sample_valid_in = 1'b1;
      tick();
      check("w0 addr", 32'(sample_addr_out), 32'(i));
      check("w0 bank", 32'(sample_bank_out), 0);
      check("w0 svalid", 32'(sample_valid_out), 1);
      if (yin_start_out) yin_pulses++;
      if (i == WS - 1) check("w0 yin on last", 32'(yin_start_out), 1);
    end
    check("w0 yin count", 32'(yin_pulses), 1);
    check("w0 yin_bank", 32'(yin_bank_out), 0);
    check("w0 state", 32'(state_out), 1);

    // Ninth sample wraps into bank 1
    tick();
    check("w1 addr", 32'(sample_addr_out), 0);
    check("w1 bank", 32'(sample_bank_out), 1);
    check("w1 yin", 32'(yin_start_out), 0);
    sample_valid_in = 1'b0;
    tick();
    check("idle svalid", 32'(sample_valid_out), 0);
    check("no ovr yet", 32'(overrun_out), 0);

    // Second boundary while still in WAIT_TAU: overrun, no yin_start
    push_samples("w1", 1, WS - 1, 1'b1);
    check("ovr yin", 32'(yin_start_out), 0);
    check("ovr flag", 32'(overrun_out), 1);
    check("ovr state", 32'(state_out), 1);
    tick();
    check("ovr sticky", 32'(overrun_out), 1);

    // Original window still completes: tau forwarded
    send_tau(11'd137);
    check("tau val", 32'(tau_out), 137);
    check("tau pulse", 32'(tau_valid_out), 1);
    check("tau state", 32'(state_out), 2);
    tick();
    check("tau pulse end", 32'(tau_valid_out), 0);
    check("tau held", 32'(tau_out), 137);

    // PSOLA done: playback starts, first read 10 cycles later
    psola_done_in = 1'b1;
    ring_empty_in = 1'b0;
    tick();
    psola_done_in = 1'b0;
    check("done state", 32'(state_out), 0);
    for (int rep = 0; rep < 2; rep++) begin
      rd_pulses = 0;
      for (int k = 1; k <= PD; k++) begin
        tick();
        if (k < PD && read_trigger_out) rd_pulses++;
        if (k == PD) check("rd on terminal", 32'(read_trigger_out), 1);
      end
      check("rd early", 32'(rd_pulses), 0);
    end

    // Empty ring across one terminal count: no read, underrun set
    ring_empty_in = 1'b1;
    rd_pulses = 0;
    for (int k = 1; k <= PD; k++) begin
      tick();
      if (read_trigger_out) rd_pulses++;
      if (k == PD - 1) check("unr before", 32'(underrun_out), 0);
    end
    check("unr no rd", 32'(rd_pulses), 0);
    check("unr flag", 32'(underrun_out), 1);
    ring_empty_in = 1'b0;
    for (int k = 1; k <= PD; k++) tick();
    check("rd resumes", 32'(read_trigger_out), 1);
    check("unr sticky", 32'(underrun_out), 1);

    // Fresh start for the coincident boundary/done case
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    push_samples("c0", 0, WS, 1'b0);
    check("c0 state", 32'(state_out), 1);
    send_tau(11'd1500);
    check("c0 tau", 32'(tau_out), 1500);
    check("c0 state2", 32'(state_out), 2);
    push_samples("c1", 0, WS - 1, 1'b1);
    sample_valid_in = 1'b1;
    psola_done_in   = 1'b1;
    tick();
    sample_valid_in = 1'b0;
    psola_done_in   = 1'b0;
    check("coin yin", 32'(yin_start_out), 1);
    check("coin yin_bank", 32'(yin_bank_out), 1);
    check("coin state", 32'(state_out), 1);
    check("coin ovr", 32'(overrun_out), 0);
    send_tau(11'd42);
    check("coin state2", 32'(state_out), 2);
    repeat (2) tick();

    // Asynchronous reset mid-WAIT_PSOLA with cadence running
    #2 rst_in = 1'b0;
    #1;
    check_reset_values("async");
    tick();
    rst_in = 1'b1;
    rd_pulses = 0;
    for (int k = 0; k < 3 * PD; k++) begin
      tick();
      if (read_trigger_out) rd_pulses++;
    end
    check("post-reset rd", 32'(rd_pulses), 0);
    check("post-reset state", 32'(state_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
